// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one request at a time to
// instruction memory, and queues returned words with their PCs for decode.
module instr_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0]   cnt_t;
  typedef logic [AW-1:0] ptr_t;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_req_pc;
  cnt_t        r_cnt;
  ptr_t        r_rd_ptr, r_wr_ptr;
  logic        r_resv;
  logic [31:0] r_mem_instr [DEPTH];
  logic [31:0] r_mem_pc    [DEPTH];

  logic        w_valid, w_space, w_go, w_grant, w_rsp, w_push, w_pop;
  logic [31:0] w_redir_pc;
  logic        w_unused;

  assign w_unused   = &{1'b0, redirect_pc_i[1:0]};
  assign w_redir_pc = {redirect_pc_i[31:2], 2'b00};
  assign w_valid    = (r_cnt != '0);
  // The reserved slot guarantees a returning response always has room.
  assign w_space    = (r_cnt + cnt_t'(r_resv)) < cnt_t'(DEPTH);
  assign w_go       = start_i && w_space;
  assign w_grant    = (r_state == S_REQ) && imem_gnt_i;
  assign w_rsp      = ((r_state == S_WAIT) || (r_state == S_DRAIN)) && imem_rvalid_i;
  assign w_push     = (r_state == S_WAIT) && imem_rvalid_i && !redirect_i;
  assign w_pop      = w_valid && instr_ready_i && !redirect_i;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_state_nxt = S_REQ;
      S_REQ:   if (imem_gnt_i) w_state_nxt = S_WAIT;
      S_WAIT,
      S_DRAIN: if (imem_rvalid_i) w_state_nxt = w_go ? S_REQ : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (redirect_i) begin
      case (r_state)
        S_REQ:   w_state_nxt = imem_gnt_i ? S_DRAIN : S_REQ;
        // A response landing on the redirect edge retires the only
        // outstanding request, so there is nothing left to drain.
        S_WAIT,
        S_DRAIN: w_state_nxt = imem_rvalid_i ? S_REQ : S_DRAIN;
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_cnt      <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_resv     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_i)   r_fetch_pc <= w_redir_pc;
      else if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_grant) r_req_pc <= r_fetch_pc;
      if (w_grant)    r_resv <= 1'b1;
      else if (w_rsp) r_resv <= 1'b0;
      if (redirect_i) begin
        r_cnt    <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + ptr_t'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + ptr_t'(1);
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + cnt_t'(1);
          2'b01:   r_cnt <= r_cnt - cnt_t'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= imem_rdata_i;
      r_mem_pc[r_wr_ptr]    <= r_req_pc;
    end
  end

  assign imem_req_o    = (r_state == S_REQ);
  assign imem_addr_o   = r_fetch_pc;
  assign instr_valid_o = w_valid;
  assign instr_o       = w_valid ? r_mem_instr[r_rd_ptr] : 32'h0;
  assign instr_pc_o    = w_valid ? r_mem_pc[r_rd_ptr]    : 32'h0;

endmodule
